// File: rtl/ntt_out_serializer.sv
// ---------------------------------------------------------------------------
// ntt_out_serializer
//
// Purpose:
//   This block sits after the N-point NTT. It captures each parallel result
//   vector in one of two banks (ping-pong). It then streams the captured
//   coefficients one per cycle over a valid/ready interface. The order is
//   natural or bit-reversed. The NTT cannot be stalled, so a vector that
//   arrives while both banks are full is dropped. A sticky overflow flag
//   records the drop.
//
// Ports:
//   clk            clock, rising edge
//   r              asynchronous active-low reset
//   coeffs_in      N x WIDTH parallel vector, element i = coefficient i
//   valid_in       coeffs_in valid this cycle
//   in_ready       a bank is free; a vector presented now is captured
//   coeff_out      current serial coefficient
//   out_valid      coeff_out valid
//   out_ready      sink accepts coeff_out this cycle
//   out_last       coeff_out is the final element of its vector
//   out_index      original vector index of coeff_out
//   overflow       sticky: a valid_in vector was dropped
//   clear_overflow synchronous clear of overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module ntt_out_serializer #(
    parameter int WIDTH  = 12,
    parameter int N      = 8,
    parameter int BITREV = 0,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk,
    input  logic                      r,
    input  logic [N-1:0][WIDTH-1:0]   coeffs_in,
    input  logic                      valid_in,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          coeff_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [IW-1:0]             out_index,
    output logic                      overflow,
    input  logic                      clear_overflow
);

    // Two banks of N coefficients each. The contents are don't-care after
    // reset, so these registers have no reset.
    logic [WIDTH-1:0] bank_mem [2][N];

    logic [1:0]    count_reg;
    logic [1:0]    count_next;
    logic          wp_reg;
    logic          rp_reg;
    logic [IW-1:0] idx_reg;
    logic          overflow_reg;

    logic          capture;
    logic          drop;
    logic          xfer;
    logic          idx_last;
    logic          last_xfer;
    logic [IW-1:0] order_idx;

    // in_ready comes from the registered count only. A bank that frees up
    // in this cycle is not offered until the next cycle.
    assign in_ready  = (count_reg < 2'd2);
    assign out_valid = (count_reg != 2'd0);

    assign capture   = valid_in & in_ready;
    assign drop      = valid_in & ~in_ready;
    assign xfer      = out_valid & out_ready;
    assign idx_last  = (idx_reg == IW'(N - 1));
    assign last_xfer = xfer & idx_last;

    // Emission order. In bit-reversed mode, bit gi of the element index is
    // bit IW-1-gi of the beat counter.
    generate
        if (BITREV != 0) begin : g_bitrev
            for (genvar gi = 0; gi < IW; gi++) begin : g_bit
                assign order_idx[gi] = idx_reg[IW-1-gi];
            end
        end else begin : g_natural
            assign order_idx = idx_reg;
        end
    endgenerate

    assign coeff_out = bank_mem[rp_reg][order_idx];
    assign out_index = order_idx;
    assign out_last  = out_valid & idx_last;
    assign overflow  = overflow_reg;

    // A capture and a final-beat transfer in the same cycle leave the
    // occupancy unchanged.
    always_comb begin
        count_next = count_reg;
        if (capture && !last_xfer) begin
            count_next = count_reg + 2'd1;
        end else if (!capture && last_xfer) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            count_reg    <= 2'd0;
            wp_reg       <= 1'b0;
            rp_reg       <= 1'b0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (capture) begin
                wp_reg <= ~wp_reg;
            end
            if (xfer) begin
                // N is a power of two, so the counter wraps to 0 after N-1.
                idx_reg <= idx_reg + IW'(1);
                if (idx_last) begin
                    rp_reg <= ~rp_reg;
                end
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // A capture never targets the bank being read. It needs count < 2, so
    // wp points at the free bank.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                bank_mem[wp_reg][i] <= coeffs_in[i];
            end
        end
    end

endmodule

// File: tb/tb_ntt_out_serializer.sv
module tb_ntt_out_serializer;

    localparam int W  = 12;
    localparam int NN = 8;

    typedef logic [NN-1:0][W-1:0] vec_t;
    typedef struct packed {
        logic [W-1:0] val;
        logic [2:0]   ix;
        logic         last;
    } beat_t;

    logic       clk = 1'b0;
    logic       r;
    vec_t       coeffs_in;
    logic       valid_in;
    logic       out_ready;
    logic       clear_overflow;

    logic          in_ready0, out_valid0, out_last0, overflow0;
    logic [W-1:0]  coeff_out0;
    logic [2:0]    out_index0;
    logic          in_ready1, out_valid1, out_last1, overflow1;
    logic [W-1:0]  coeff_out1;
    logic [2:0]    out_index1;

    int checks = 0;
    int errors = 0;

    beat_t q0[$];
    beat_t q1[$];

    int brev_tab [NN] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    ntt_out_serializer #(.WIDTH(W), .N(NN), .BITREV(0)) dut0 (
        .clk(clk), .r(r), .coeffs_in(coeffs_in), .valid_in(valid_in),
        .in_ready(in_ready0), .coeff_out(coeff_out0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_last(out_last0), .out_index(out_index0),
        .overflow(overflow0), .clear_overflow(clear_overflow)
    );

    ntt_out_serializer #(.WIDTH(W), .N(NN), .BITREV(1)) dut1 (
        .clk(clk), .r(r), .coeffs_in(coeffs_in), .valid_in(valid_in),
        .in_ready(in_ready1), .coeff_out(coeff_out1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_last(out_last1), .out_index(out_index1),
        .overflow(overflow1), .clear_overflow(clear_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic vec_t make_vec(input int base, input int step);
        vec_t v;
        for (int i = 0; i < NN; i++) v[i] = W'((base + i * step) % 4096);
        return v;
    endfunction

    // Scoreboard monitors: one beat per accepted transfer, plus a stability
    // check while the sink stalls.
    logic  stall0 = 1'b0, stall1 = 1'b0;
    beat_t hold0, hold1, b0, b1;

    always @(negedge clk) begin
        if (r) begin
            if (stall0 && out_valid0) begin
                chk("stall_coeff0", coeff_out0, hold0.val);
                chk("stall_index0", out_index0, hold0.ix);
                chk("stall_last0", out_last0, hold0.last);
            end
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) chk("extra_beat0", out_valid0, 0);
                else begin
                    b0 = q0.pop_front();
                    chk("coeff0", coeff_out0, b0.val);
                    chk("index0", out_index0, b0.ix);
                    chk("last0", out_last0, b0.last);
                    $display("dut0 beat: coeff=%0d index=%0d last=%0d", coeff_out0, out_index0, out_last0);
                end
            end
            stall0 = out_valid0 && !out_ready;
            hold0  = '{coeff_out0, out_index0, out_last0};
        end else stall0 = 1'b0;
    end

    always @(negedge clk) begin
        if (r) begin
            if (stall1 && out_valid1) begin
                chk("stall_coeff1", coeff_out1, hold1.val);
                chk("stall_index1", out_index1, hold1.ix);
                chk("stall_last1", out_last1, hold1.last);
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) chk("extra_beat1", out_valid1, 0);
                else begin
                    b1 = q1.pop_front();
                    chk("coeff1", coeff_out1, b1.val);
                    chk("index1", out_index1, b1.ix);
                    chk("last1", out_last1, b1.last);
                    $display("dut1 beat: coeff=%0d index=%0d last=%0d", coeff_out1, out_index1, out_last1);
                end
            end
            stall1 = out_valid1 && !out_ready;
            hold1  = '{coeff_out1, out_index1, out_last1};
        end else stall1 = 1'b0;
    end

    // Drive one vector for one cycle. It is pushed to the scoreboards only
    // when the step expects it to be captured.
    task automatic send(input vec_t v, input bit exp_ready, input string tag);
        coeffs_in = v;
        valid_in  = 1'b1;
        chk({tag, "_in_ready0"}, in_ready0, exp_ready);
        chk({tag, "_in_ready1"}, in_ready1, exp_ready);
        if (exp_ready) begin
            for (int i = 0; i < NN; i++) begin
                q0.push_back('{v[i], 3'(i), (i == NN - 1)});
                q1.push_back('{v[brev_tab[i]], 3'(brev_tab[i]), (i == NN - 1)});
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", q0.size() + q1.size(), 0);
        chk("drain_out_valid0", out_valid0, 0);
        chk("drain_out_valid1", out_valid1, 0);
        chk("drain_out_last0", out_last0, 0);
    endtask

    initial begin
        r = 1'b0; coeffs_in = '0; valid_in = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_last", out_last0, 0);
        chk("rst_out_index", out_index0, 0);
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_overflow", overflow0, 0);
        repeat (2) @(posedge clk);
        #1 r = 1'b1;

        // Step 1: a single vector 0..7 with the sink always ready.
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t1_idle_valid", out_valid0, 0);
        send(make_vec(0, 1), 1'b1, "t1");
        chk("t1_valid_rise0", out_valid0, 1);
        chk("t1_valid_rise1", out_valid1, 1);
        drain(1'b0, 40);
        $display("step 1 done: single vector natural and bit-reversed");

        // Step 2: sink stalled, so A and B fill both banks and C is dropped.
        out_ready = 1'b0;
        send(make_vec(100, 3), 1'b1, "t2a");
        send(make_vec(200, 5), 1'b1, "t2b");
        chk("t2_full_in_ready", in_ready0, 0);
        chk("t2_pre_overflow", overflow0, 0);
        send(make_vec(300, 7), 1'b0, "t2c");
        chk("t2_overflow0", overflow0, 1);
        chk("t2_overflow1", overflow1, 1);
        // Step 2b: the set wins over a same-cycle clear.
        clear_overflow = 1'b1;
        send(make_vec(400, 9), 1'b0, "t2d");
        chk("t2_set_wins", overflow0, 1);
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        chk("t2_cleared", overflow0, 0);
        // Step 2c: a vector arriving on A's final beat is still dropped.
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        send(make_vec(500, 11), 1'b0, "t2e");
        chk("t2_drop_on_last", overflow0, 1);
        drain(1'b0, 40);
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        chk("t2_final_clear", overflow0, 0);
        $display("step 2 done: backpressure, drop and overflow clear");

        // Step 3: one vector every 8 cycles with the sink always ready.
        // The output must be gap-free, with no drops.
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send(make_vec((v == 0) ? 3328 : (v == 1) ? 1729 : (v == 2) ? 749 : 40, 517 + v), 1'b1, "t3");
            chk("t3_valid_after_send", out_valid0, 1);
            for (int c = 0; c < 7; c++) begin
                @(posedge clk); #1;
                chk("t3_gapless", out_valid0, 1);
            end
            chk("t3_no_overflow", overflow0, 0);
        end
        drain(1'b0, 40);
        $display("step 3 done: sustained throughput");

        // Step 4: the sink toggles ready at random mid-vector.
        out_ready = 1'b0;
        send(make_vec(4095, 1000), 1'b1, "t4a");
        send(make_vec(1234, 2049), 1'b1, "t4b");
        drain(1'b1, 400);
        $display("step 4 done: random stalls");

        // Step 5: reset mid-stream with both banks full and idx at 3.
        out_ready = 1'b0;
        send(make_vec(10, 1), 1'b1, "t5a");
        send(make_vec(20, 1), 1'b1, "t5b");
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        send(make_vec(30, 1), 1'b0, "t5c");
        chk("t5_pre_overflow", overflow0, 1);
        #2 r = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid0, 0);
        chk("t5_rst_last", out_last0, 0);
        chk("t5_rst_index", out_index0, 0);
        chk("t5_rst_in_ready", in_ready0, 1);
        chk("t5_rst_overflow", overflow0, 0);
        chk("t5_rst_valid1", out_valid1, 0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        r = 1'b1;
        out_ready = 1'b1;
        send(make_vec(777, 333), 1'b1, "t5f");
        drain(1'b0, 40);
        $display("step 5 done: mid-stream reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
